// File: rtl/keyboard_pkg.sv
// Shared types and constants for the PS/2-to-matrix keyboard scanner.
package keyboard_pkg;

  localparam int unsigned HOLD_CYCLES_DEFAULT = 200000;
  localparam int unsigned MODIF_W             = 3;

  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_ALT    = 8'h11;
  localparam logic [7:0] SC_CTRL   = 8'h14;

  typedef struct packed {
    logic       ext;
    logic [7:0] code;
    logic       pressed;
  } key_event_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] row;
    logic [2:0] col;
  } key_pos_t;

  // One-hot active-low modifier bit touched by a scancode; zero for ordinary keys.
  function automatic logic [MODIF_W-1:0] modifier_mask(input logic [7:0] code);
    case (code)
      SC_LSHIFT, SC_RSHIFT: return 3'b001;
      SC_ALT:               return 3'b010;
      SC_CTRL:              return 3'b100;
      default:              return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/keyboard_matrix_scanner_if.sv
// Host-facing signal bundle of the keyboard matrix scanner.
interface keyboard_matrix_scanner_if #(
  parameter int unsigned ROWS = 8,
  parameter int unsigned COLS = 8
);
  logic [10:0]     ps2_key;
  logic            all_up;
  logic [ROWS-1:0] addr;
  logic [COLS-1:0] kb_cols;
  logic [2:0]      modif;
  logic            overflow;

  modport master (output ps2_key, all_up, addr, input kb_cols, modif, overflow);
  modport slave  (input ps2_key, all_up, addr, output kb_cols, modif, overflow);
endinterface

// File: rtl/ps2_keymap.sv
// Combinational scancode -> matrix position ROM. KBD_EXTENDED_KEYS_EN gives E0-prefixed
// codes their own positions; without it the extended flag is ignored.
module ps2_keymap
  import keyboard_pkg::*;
#(
  parameter int unsigned ROWS = 8,
  parameter int unsigned COLS = 8
) (
  input  logic       ext,
  input  logic [7:0] code,
  output key_pos_t   pos_c
);

  function automatic key_pos_t pos_at(input int unsigned r, input int unsigned c);
    key_pos_t p;
    p.valid = 1'b1;
    p.row   = 4'(r);
    p.col   = 3'(c);
    return p;
  endfunction

  function automatic key_pos_t base_lookup(input logic [7:0] c);
    case (c)
      8'h5A: return pos_at(0, 0);
      8'h66: return pos_at(0, 1);
      8'h76: return pos_at(0, 7);
      8'h0D: return pos_at(1, 7);
      8'h75: return pos_at(3, 3);
      8'h16: return pos_at(4, 7);
      8'h1E: return pos_at(4, 6);
      8'h26: return pos_at(4, 5);
      8'h15: return pos_at(5, 7);
      8'h1D: return pos_at(5, 6);
      8'h24: return pos_at(5, 5);
      8'h2D: return pos_at(5, 4);
      8'h1C: return pos_at(6, 6);
      8'h1B: return pos_at(6, 5);
      8'h23: return pos_at(6, 4);
      8'h2B: return pos_at(6, 3);
      8'h29: return pos_at(7, 0);
      8'h05: return pos_at(9, 0);  // F1 sits beyond an 8-row matrix
      default: return key_pos_t'(0);
    endcase
  endfunction

  key_pos_t raw;

`ifdef KBD_EXTENDED_KEYS_EN
  always_comb begin
    raw = key_pos_t'(0);
    if (ext) begin
      case (code)
        8'h75, 8'h72: raw = pos_at(1, 5);
        8'h6B, 8'h74: raw = pos_at(2, 5);
        default:      raw = key_pos_t'(0);
      endcase
    end else begin
      raw = base_lookup(code);
    end
  end
`else
  logic unused_ext;
  assign unused_ext = ext;
  always_comb raw = base_lookup(code);
`endif

  // Positions outside the configured matrix are reported as unmapped.
  always_comb begin
    pos_c       = raw;
    pos_c.valid = raw.valid && (32'(raw.row) < ROWS) && (32'(raw.col) < COLS);
  end

endmodule

// File: rtl/keyboard_matrix_scanner.sv
// PS/2 key events -> emulated active-low key matrix with event queue, press hold timer
// and modifier bypass. Optional macro: KBD_EXTENDED_KEYS_EN (see ps2_keymap).
module keyboard_matrix_scanner
  import keyboard_pkg::*;
#(
  parameter int unsigned ROWS        = 8,
  parameter int unsigned COLS        = 8,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEFAULT
) (
  input logic                      clk_sys,
  input logic                      reset_n,
  keyboard_matrix_scanner_if.slave kbd
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned TMR_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned COL_W = (COLS > 1) ? $clog2(COLS) : 1;

  logic [ROWS-1:0][COLS-1:0]    keys_q, keys_d;
  key_event_t [FIFO_DEPTH-1:0]  fifo_q, fifo_d;
  logic [PTR_W-1:0]             rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]             count_q, count_d;
  logic [TMR_W-1:0]             timer_q, timer_d;
  logic [MODIF_W-1:0]           modif_q, modif_d;
  logic                         overflow_q, overflow_d;
  logic                         primed_q, primed_d;
  logic                         tog_q, tog_d;

  key_event_t         head, new_evt;
  key_pos_t           head_pos;
  logic [MODIF_W-1:0] mod_mask;
  logic               event_det, stall, pop, push, push_ok, fifo_full;

  assign head      = fifo_q[rd_ptr_q];
  assign new_evt   = {kbd.ps2_key[8], kbd.ps2_key[7:0], kbd.ps2_key[9]};
  assign mod_mask  = modifier_mask(new_evt.code);
  assign event_det = primed_q && (kbd.ps2_key[10] != tog_q);
  assign fifo_full = (count_q == CNT_W'(FIFO_DEPTH));
  // Only a mapped release waits for the hold timer; presses and junk drain freely.
  assign stall     = head_pos.valid && !head.pressed && (timer_q != '0);
  assign pop       = (count_q != '0) && !stall && !kbd.all_up;
  assign push      = event_det && (mod_mask == '0) && !kbd.all_up;

  ps2_keymap #(.ROWS(ROWS), .COLS(COLS)) u_keymap (
    .ext   (head.ext),
    .code  (head.code),
    .pos_c (head_pos)
  );

  // Next-state: queue, matrix, timer and modifiers.
  always_comb begin
    keys_d     = keys_q;
    fifo_d     = fifo_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    timer_d    = (timer_q != '0) ? timer_q - TMR_W'(1) : timer_q;
    modif_d    = modif_q;
    overflow_d = overflow_q;
    primed_d   = 1'b1;
    tog_d      = kbd.ps2_key[10];
    push_ok    = 1'b0;

    if (kbd.all_up) begin
      keys_d     = '1;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      timer_d    = '0;
      modif_d    = '1;
      overflow_d = 1'b0;
    end else begin
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (head_pos.valid) begin
          keys_d[ROW_W'(head_pos.row)][COL_W'(head_pos.col)] = !head.pressed;
          if (head.pressed) timer_d = TMR_W'(HOLD_CYCLES);
        end
      end
      if (event_det && (mod_mask != '0))
        modif_d = new_evt.pressed ? (modif_q & ~mod_mask) : (modif_q | mod_mask);
      if (push) begin
        if (fifo_full && !pop) begin
          overflow_d = 1'b1;
        end else begin
          push_ok          = 1'b1;
          fifo_d[wr_ptr_q] = new_evt;
          wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end
      end
      count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      keys_q     <= '1;
      fifo_q     <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      timer_q    <= '0;
      modif_q    <= '1;
      overflow_q <= 1'b0;
      primed_q   <= 1'b0;
      tog_q      <= 1'b0;
    end else begin
      keys_q     <= keys_d;
      fifo_q     <= fifo_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      timer_q    <= timer_d;
      modif_q    <= modif_d;
      overflow_q <= overflow_d;
      primed_q   <= primed_d;
      tog_q      <= tog_d;
    end
  end

  // Column readout is a live AND across every selected row.
  logic [COLS-1:0] kb_cols_c;
  always_comb begin
    kb_cols_c = '1;
    for (int r = 0; r < ROWS; r++)
      if (!kbd.addr[r]) kb_cols_c = kb_cols_c & keys_q[r];
  end

  assign kbd.kb_cols  = kb_cols_c;
  assign kbd.modif    = modif_q;
  assign kbd.overflow = overflow_q;

endmodule

// File: tb/tb_keyboard_matrix_scanner.sv
// Scoreboard bench: a cycle-level reference model predicts kb_cols/modif/overflow.
module tb_keyboard_matrix_scanner;
  import keyboard_pkg::*;

  localparam int unsigned ROWS        = 8;
  localparam int unsigned COLS        = 8;
  localparam int unsigned FIFO_DEPTH  = 4;
  localparam int unsigned HOLD_CYCLES = 100;
`ifdef KBD_EXTENDED_KEYS_EN
  localparam bit EXT_EN = 1'b1;
`else
  localparam bit EXT_EN = 1'b0;
`endif

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk_sys = ~clk_sys;

  keyboard_matrix_scanner_if #(.ROWS(ROWS), .COLS(COLS)) kbd ();

  keyboard_matrix_scanner #(
    .ROWS(ROWS), .COLS(COLS), .FIFO_DEPTH(FIFO_DEPTH), .HOLD_CYCLES(HOLD_CYCLES)
  ) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .kbd     (kbd)
  );

  typedef struct {
    logic [COLS-1:0] cols;
    logic [2:0]      modif;
    logic            ovf;
    string           tag;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state
  logic [COLS-1:0] m_keys [ROWS];
  key_event_t      m_q[$];
  int              m_edge = 0;
  int              m_last_press;
  logic            m_primed, m_tog, m_ovf;
  logic [2:0]      m_modif;

  logic [10:0]     cur_ps2  = '0;
  logic            cur_au   = 1'b0;
  logic [ROWS-1:0] cur_addr = '1;
  logic            cur_rn   = 1'b0;
  string           cur_tag  = "reset";

  logic [7:0] codes [26] = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h15, 8'h1D, 8'h24, 8'h2D, 8'h16,
                             8'h1E, 8'h26, 8'h5A, 8'h66, 8'h76, 8'h0D, 8'h75, 8'h72, 8'h6B,
                             8'h74, 8'h29, 8'h05, 8'h00, 8'h12, 8'h59, 8'h11, 8'h14};

  // Key layout table: returns 1 and the position when the key lands inside the matrix.
  function automatic bit ref_map(input logic ext, input logic [7:0] code,
                                 output int row, output int col);
    int r = -1;
    int c = -1;
    if (EXT_EN && ext) begin
      case (code)
        8'h75, 8'h72: begin r = 1; c = 5; end
        8'h6B, 8'h74: begin r = 2; c = 5; end
        default: ;
      endcase
    end else begin
      case (code)
        8'h5A: begin r = 0; c = 0; end
        8'h66: begin r = 0; c = 1; end
        8'h76: begin r = 0; c = 7; end
        8'h0D: begin r = 1; c = 7; end
        8'h75: begin r = 3; c = 3; end
        8'h16: begin r = 4; c = 7; end
        8'h1E: begin r = 4; c = 6; end
        8'h26: begin r = 4; c = 5; end
        8'h15: begin r = 5; c = 7; end
        8'h1D: begin r = 5; c = 6; end
        8'h24: begin r = 5; c = 5; end
        8'h2D: begin r = 5; c = 4; end
        8'h1C: begin r = 6; c = 6; end
        8'h1B: begin r = 6; c = 5; end
        8'h23: begin r = 6; c = 4; end
        8'h2B: begin r = 6; c = 3; end
        8'h29: begin r = 7; c = 0; end
        8'h05: begin r = 9; c = 0; end
        default: ;
      endcase
    end
    row = r;
    col = c;
    return (r >= 0) && (r < int'(ROWS)) && (c >= 0) && (c < int'(COLS));
  endfunction

  function automatic int mod_index(input logic [7:0] code);
    if (code == 8'h12 || code == 8'h59) return 0;
    if (code == 8'h11) return 1;
    if (code == 8'h14) return 2;
    return -1;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < ROWS; r++) m_keys[r] = '1;
    m_q.delete();
    m_last_press = -1000000;
    m_primed     = 1'b0;
    m_tog        = 1'b0;
    m_modif      = 3'b111;
    m_ovf        = 1'b0;
  endtask

  // One clock edge of the reference: drain the head first, then enqueue the new event.
  task automatic model_edge();
    bit         det, popped;
    int         r, c, mi, sz;
    key_event_t e;
    m_edge++;
    if (!reset_n) begin
      model_reset();
      return;
    end
    det = m_primed && (kbd.ps2_key[10] != m_tog);
    if (kbd.all_up) begin
      for (int k = 0; k < ROWS; k++) m_keys[k] = '1;
      m_q.delete();
      m_last_press = -1000000;
      m_modif      = 3'b111;
      m_ovf        = 1'b0;
    end else begin
      sz     = m_q.size();
      popped = 0;
      if (sz > 0) begin
        e = m_q[0];
        if (!ref_map(e.ext, e.code, r, c)) begin
          popped = 1;
        end else if (e.pressed) begin
          m_keys[r][c] = 1'b0;
          m_last_press = m_edge;
          popped       = 1;
        end else if (m_edge - m_last_press > int'(HOLD_CYCLES)) begin
          m_keys[r][c] = 1'b1;
          popped       = 1;
        end
        if (popped) void'(m_q.pop_front());
      end
      if (det) begin
        mi = mod_index(kbd.ps2_key[7:0]);
        if (mi >= 0) m_modif[mi] = !kbd.ps2_key[9];
        else if (sz == int'(FIFO_DEPTH) && !popped) m_ovf = 1'b1;
        else m_q.push_back({kbd.ps2_key[8], kbd.ps2_key[7:0], kbd.ps2_key[9]});
      end
    end
    m_tog    = kbd.ps2_key[10];
    m_primed = 1'b1;
  endtask

  task automatic push_expect();
    exp_t x;
    x.cols = '1;
    for (int r = 0; r < ROWS; r++)
      if (!kbd.addr[r]) x.cols = x.cols & m_keys[r];
    x.modif = m_modif;
    x.ovf   = m_ovf;
    x.tag   = cur_tag;
    sb.push_back(x);
  endtask

  // Advance one edge, then present the cur_* inputs for the following edge.
  task automatic tick();
    @(posedge clk_sys);
    model_edge();
    #1;
    kbd.ps2_key = cur_ps2;
    kbd.all_up  = cur_au;
    kbd.addr    = cur_addr;
    if (cur_rn != reset_n) begin
      reset_n = cur_rn;
      if (!cur_rn) model_reset();
    end
    push_expect();
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input logic [7:0] code, input logic ext, input logic pr,
                      input logic au = 1'b0);
    cur_ps2 = {~cur_ps2[10], pr, ext, code};
    cur_au  = au;
    tick();
    cur_au  = 1'b0;
  endtask

  always @(negedge clk_sys) begin : monitor
    exp_t x;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      n_tests++;
      if (kbd.kb_cols !== x.cols || kbd.modif !== x.modif || kbd.overflow !== x.ovf) begin
        n_fail++;
        $display("FAIL %s @%0t: got kb_cols=%h modif=%b overflow=%b, want kb_cols=%h modif=%b overflow=%b",
                 x.tag, $time, kbd.kb_cols, kbd.modif, kbd.overflow, x.cols, x.modif, x.ovf);
      end
    end
  end

  initial begin
    model_reset();
    kbd.ps2_key = '0;
    kbd.all_up  = 1'b0;
    kbd.addr    = '1;

    cur_tag = "reset_toggle_high"; cur_ps2 = 11'h400; cur_addr = 8'hBF;
    idle(3);
    cur_rn = 1'b1;
    idle(4);

    cur_tag = "hold_press_release";
    send(8'h1C, 1'b0, 1'b1);
    idle(59);
    send(8'h1C, 1'b0, 1'b0);
    idle(110);

    cur_tag = "overflow_while_stalled"; cur_addr = 8'h00;
    send(8'h1B, 1'b0, 1'b1);
    idle(2);
    send(8'h1B, 1'b0, 1'b0);
    send(8'h23, 1'b0, 1'b1);
    send(8'h23, 1'b0, 1'b0);
    send(8'h2B, 1'b0, 1'b1);
    send(8'h15, 1'b0, 1'b1);
    idle(230);

    cur_tag = "shift_then_all_up";
    send(8'h12, 1'b0, 1'b1);
    idle(2);
    send(8'h29, 1'b0, 1'b1);
    idle(3);
    cur_au = 1'b1; tick(); cur_au = 1'b0;
    idle(3);
    cur_tag = "event_with_all_up";
    send(8'h1C, 1'b0, 1'b1, 1'b1);
    idle(4);

    cur_tag = "extended_arrow";
    send(8'h75, 1'b1, 1'b1);
    idle(3);
    send(8'h75, 1'b1, 1'b0);
    idle(105);

    cur_tag = "unmapped_and_out_of_range";
    send(8'h05, 1'b0, 1'b1);
    send(8'h00, 1'b0, 1'b1);
    send(8'h16, 1'b0, 1'b1);
    idle(4);
    cur_au = 1'b1; tick(); cur_au = 1'b0;
    idle(2);

    cur_tag = "reset_with_queue";
    send(8'h1E, 1'b0, 1'b1);
    idle(1);
    send(8'h1E, 1'b0, 1'b0);
    send(8'h26, 1'b0, 1'b1);
    send(8'h26, 1'b0, 1'b0);
    cur_rn = 1'b0;
    idle(2);
    cur_rn = 1'b1;
    idle(10);

    cur_tag = "random";
    for (int i = 0; i < 4000; i++) begin
      int p;
      p = int'($urandom_range(0, 999));
      if ($urandom_range(0, 3) == 0) cur_addr = ROWS'(~(32'd1 << $urandom_range(0, ROWS - 1)));
      else cur_addr = ROWS'($urandom);
      if (p < 3) begin
        cur_rn = 1'b0; idle(2); cur_rn = 1'b1;
      end else if (p < 13) begin
        cur_au = 1'b1; tick(); cur_au = 1'b0;
      end else if (p < 350) begin
        send(codes[$urandom_range(0, 25)], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else begin
        tick();
      end
    end
    idle(3);

    @(negedge clk_sys);
    #1;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
